// File: rtl/sdu_uart_tx.sv
// Buffered 8-bit UART transmitter (8N1, LSB first) with a byte FIFO in front of the serialiser.
// Define SDU_UART_TX_PARITY_EN to insert an even-parity bit between D7 and STOP.
module sdu_uart_tx #(
  parameter int unsigned DIV        = 868,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [7:0]            tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  txd,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   fifo_cnt
);

  localparam int unsigned PTR_W = DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned TMR_W = 16;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef SDU_UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  logic [2:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       idx_q, idx_d;
  logic             txd_q, txd_d;
  logic             bit_tick;
  logic [7:0]       head;
`ifdef SDU_UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  assign tx_ready = (cnt_q != CNT_W'(DEPTH));
  assign push     = tx_valid && tx_ready;
  assign head     = mem[rd_ptr_q];
  assign bit_tick = (timer_q == TMR_W'(DIV - 1));
  assign fifo_cnt = cnt_q;
  assign txd      = txd_q;
  assign busy     = (state_q != IDLE) || (cnt_q != '0);

  // Storage has no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= tx_data;
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Next-state, pop decision and next line value.
  always_comb begin
    state_d = state_q;
    timer_d = bit_tick ? '0 : timer_q + TMR_W'(1);
    shift_d = shift_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    txd_d   = 1'b1;
`ifdef SDU_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (cnt_q != '0) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
          idx_d   = 3'd0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef SDU_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef SDU_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_tick) begin
          if (cnt_q != '0) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      shift_d = head;
      timer_d = '0;
`ifdef SDU_UART_TX_PARITY_EN
      par_d   = ^head;
`endif
    end

    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
`ifdef SDU_UART_TX_PARITY_EN
      PARITY:  txd_d = par_d;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      shift_q  <= '0;
      idx_q    <= '0;
      txd_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
`ifdef SDU_UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      txd_q    <= txd_d;
      cnt_q    <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
`ifdef SDU_UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

endmodule
